// File: rtl/synapse_weight_loader.sv
// Double-buffered serial-to-parallel loader for the ONN synapse weight matrix.
// A shadow register fills from the 1-bit stream; the active bus updates only on commit.
//
// state  | meaning
// IDLE   | waiting for start; weights_out holds the last committed frame
// LOAD   | accepting qualified bits into the shadow register
// COMMIT | copying shadow to weights_out, pulsing load_done
module synapse_weight_loader #(
    parameter int ROWS      = 5,
    parameter int COLS      = 3,
    parameter int W         = 4,
    parameter int MSB_FIRST = 1,
    localparam int N        = ROWS * COLS * W,
    localparam int CW       = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          bit_in,
    input  logic          bit_valid,
    output logic [N-1:0]  weights_out,
    output logic          busy,
    output logic          load_done,
    output logic [CW-1:0] bit_cnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  shadow_q;
    logic [N-1:0]  weights_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    logic [CW-1:0] elem;
    logic [CW-1:0] bitp;
    logic [PW-1:0] pos;

    // Shadow bit index for the next accepted bit; elements fill row-major from bit 0 up.
    always_comb begin
        elem = cnt_q / CW'(W);
        bitp = cnt_q % CW'(W);
        if (MSB_FIRST != 0) begin
            pos = PW'(elem * CW'(W) + (CW'(W - 1) - bitp));
        end else begin
            pos = PW'(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            weights_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    // start here is an abort: the bit on this cycle is dropped
                    if (start) begin
                        cnt_q <= '0;
                    end else if (bit_valid) begin
                        shadow_q[pos] <= bit_in;
                        cnt_q         <= cnt_q + CW'(1);
                        if (cnt_q == CW'(N - 1)) begin
                            state_q <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    weights_q <= shadow_q;
                    done_q    <= 1'b1;
                    cnt_q     <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign weights_out = weights_q;
    assign busy        = busy_q;
    assign load_done   = done_q;
    assign bit_cnt     = cnt_q;

endmodule

// File: tb/tb_synapse_weight_loader.sv
// Directed bench for synapse_weight_loader: default 5x3x4 MSB-first instance plus
// a 2x2x8 LSB-first instance; expected frames go through scoreboard queues.
module tb_synapse_weight_loader;

    localparam logic [63:0] PAT   = 64'h0FFF00FFFFF00FFF;
    localparam logic [63:0] ONES  = 64'h0FFFFFFFFFFFFFFF;
    localparam logic [63:0] RAMP  = 64'h0EDCBA9876543210;
    localparam logic [63:0] PAT2  = 64'h000000003CA58001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic [59:0] weights_out;
    logic        busy;
    logic        load_done;
    logic [6:0]  bit_cnt;

    logic        start2 = 1'b0;
    logic        bit_in2 = 1'b0;
    logic        bit_valid2 = 1'b0;
    logic [31:0] weights_out2;
    logic        busy2;
    logic        load_done2;
    logic [5:0]  bit_cnt2;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp2_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) if (load_done) done_cnt <= done_cnt + 1;

    synapse_weight_loader u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .weights_out(weights_out), .busy(busy), .load_done(load_done), .bit_cnt(bit_cnt)
    );

    synapse_weight_loader #(.ROWS(2), .COLS(2), .W(8), .MSB_FIRST(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bit_in(bit_in2), .bit_valid(bit_valid2),
        .weights_out(weights_out2), .busy(busy2), .load_done(load_done2), .bit_cnt(bit_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic b);
        start = s;
        bit_valid = v;
        bit_in = b;
        step();
    endtask

    // Streams one 60-bit frame; s[b] is the b-th bit on the wire.
    task automatic send1(input logic [63:0] s, input bit do_start, input bit gaps,
                         input logic [63:0] prior);
        if (do_start) drive(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 60; b++) begin
            drive(1'b0, 1'b1, s[b]);
            if (b == 0) check("first_bit_cnt", bit_cnt, 1);
            if (b == 30) check("hold_mid_frame", weights_out, prior);
            if (gaps && (b % 4 == 3) && b != 59) begin
                repeat (3) drive(1'b0, 1'b0, ~s[b]);
                check("gap_cnt_frozen", bit_cnt, b + 1);
                check("gap_weights_hold", weights_out, prior);
            end
        end
        check("pre_commit_hold", weights_out, prior);
        check("pre_commit_no_done", load_done, 0);
    endtask

    task automatic wait_done1();
        int lat = 0;
        while (!load_done && lat < 8) begin
            drive(1'b0, 1'b0, 1'b0);
            lat++;
        end
        check("done_latency", lat, 1);
        check("done_seen", load_done, 1);
        check("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("commit_weights", weights_out, exp_q.pop_front());
        check("post_commit_cnt", bit_cnt, 0);
        check("post_commit_busy", busy, 0);
        drive(1'b0, 1'b0, 1'b0);
        check("done_one_cycle", load_done, 0);
    endtask

    initial begin
        logic [63:0] s1;
        logic [63:0] s3;
        logic [63:0] s2;
        logic [7:0]  bytes2 [4];
        int d0;

        s1 = '0;
        for (int b = 0; b < 60; b++)
            if (b < 12 || (b >= 20 && b < 40) || b >= 48) s1[b] = 1'b1;
        s3 = '0;
        for (int e = 0; e < 15; e++)
            for (int p = 0; p < 4; p++) s3[e*4+p] = e[3-p];
        bytes2[0] = 8'h01; bytes2[1] = 8'h80; bytes2[2] = 8'hA5; bytes2[3] = 8'h3C;
        s2 = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8; j++) s2[i*8+j] = bytes2[i][j];

        // Reset
        #2 rst_n = 1'b0;
        #1;
        check("rst_weights", weights_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", load_done, 0);
        check("rst_cnt", bit_cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // start with a valid bit in IDLE: that bit is dropped; then gapped frame
        exp_q.push_back(PAT);
        drive(1'b1, 1'b1, 1'b1);
        check("start_bit_ignored", bit_cnt, 0);
        check("busy_in_load", busy, 1);
        send1(s1, 1'b0, 1'b1, 64'h0);
        wait_done1();

        // Abort at bit 30 of an all-zero frame, then restart with all ones
        d0 = done_cnt;
        exp_q.push_back(ONES);
        drive(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 30; b++) drive(1'b0, 1'b1, 1'b0);
        check("abort_pre_cnt", bit_cnt, 30);
        drive(1'b1, 1'b1, 1'b1);
        check("abort_cnt_clear", bit_cnt, 0);
        check("abort_busy", busy, 1);
        check("abort_weights_hold", weights_out, PAT);
        send1(ONES, 1'b0, 1'b0, PAT);
        wait_done1();
        check("restart_single_done", done_cnt - d0, 1);

        // start in COMMIT is ignored
        exp_q.push_back(PAT);
        send1(s1, 1'b1, 1'b0, ONES);
        start = 1'b1;
        step();
        start = 1'b0;
        check("commit_done", load_done, 1);
        check("commit_weights_plain", weights_out, exp_q.pop_front());
        check("commit_start_ignored", busy, 0);
        drive(1'b0, 1'b0, 1'b0);

        // Asymmetric elements expose bit ordering
        exp_q.push_back(RAMP);
        send1(s3, 1'b1, 1'b0, PAT);
        wait_done1();

        // Async reset mid-frame
        drive(1'b1, 1'b0, 1'b0);
        for (int b = 0; b < 25; b++) drive(1'b0, 1'b1, s1[b]);
        check("pre_rst_cnt", bit_cnt, 25);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_weights", weights_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cnt", bit_cnt, 0);
        step();
        rst_n = 1'b1;
        repeat (5) drive(1'b0, 1'b1, 1'b1);
        check("no_start_cnt", bit_cnt, 0);
        check("no_start_busy", busy, 0);
        check("no_start_weights", weights_out, 0);

        // 2x2x8 LSB-first instance
        exp2_q.push_back(PAT2);
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int b = 0; b < 32; b++) begin
            bit_valid2 = 1'b1;
            bit_in2 = s2[b];
            step();
        end
        bit_valid2 = 1'b0;
        check("lsb_cnt_full", bit_cnt2, 32);
        check("lsb_hold", weights_out2, 0);
        begin
            int lat2 = 0;
            while (!load_done2 && lat2 < 8) begin
                step();
                lat2++;
            end
            check("lsb_done_latency", lat2, 1);
        end
        check("lsb_sb_has_entry", exp2_q.size() > 0, 1);
        if (exp2_q.size() > 0) check("lsb_weights", weights_out2, exp2_q.pop_front());
        check("lsb_cnt_clear", bit_cnt2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
